tlv_sample_filter: RTL and testbench

- Downstream consumer of the TLV493 sensor block.
- Takes each decoded magnetic/temperature sample and validates frame continuity (frm sequence).
- Applies per-axis offset correction, then a moving average over 2^LOG2_DEPTH samples per channel.
- Exposes filtered results and error counters on an Avalon-MM slave for the HPS.

---
 rtl/tlv_sample_filter_pkg.sv | 42 ++++
 rtl/tlv_sample_filter_if.sv | 19 +
 rtl/tlv_moving_average.sv | 64 ++++++
 rtl/tlv_sample_filter.sv | 210 +++++++++++++++++++++
 tb/tb_tlv_sample_filter.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tlv_sample_filter_pkg.sv
// Shared definitions for the TLV493 sample filter: FSM states, register map,
// channel count and the width of one buffered sample.
// Optional feature macro: TLV_FILTER_SATURATE_EN (clip corrected axes to 12 bits).
package tlv_filter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CHECK  = 2'd1,
      UPDATE = 2'd2,
      DONE   = 2'd3
   } state_t;

   // Three magnetic axes plus temperature
   localparam int NUM_CHANNELS = 4;

   // Register indices (address >> 8)
   localparam logic [7:0] REG_X         = 8'd0;
   localparam logic [7:0] REG_Y         = 8'd1;
   localparam logic [7:0] REG_Z         = 8'd2;
   localparam logic [7:0] REG_TEMP      = 8'd3;
   localparam logic [7:0] REG_OVERRUN   = 8'd4;
   localparam logic [7:0] REG_FRAME_ERR = 8'd5;
   localparam logic [7:0] REG_STATUS    = 8'd6;
   localparam logic [7:0] REG_OFFSET_X  = 8'd7;
   localparam logic [7:0] REG_OFFSET_Y  = 8'd8;
   localparam logic [7:0] REG_OFFSET_Z  = 8'd9;

   // Write-side meaning of indices 0..4
   localparam logic [7:0] WREG_OFFSET_X = 8'd0;
   localparam logic [7:0] WREG_OFFSET_Y = 8'd1;
   localparam logic [7:0] WREG_OFFSET_Z = 8'd2;
   localparam logic [7:0] WREG_FLUSH    = 8'd3;
   localparam logic [7:0] WREG_CLEAR    = 8'd4;

   // Width of one buffered sample: clipped axes fit in 12 bits, otherwise 13
`ifdef TLV_FILTER_SATURATE_EN
   localparam int ENTRY_W = 12;
`else
   localparam int ENTRY_W = 13;
`endif

endpackage

// File: rtl/tlv_sample_filter_if.sv
// Avalon-MM slave bus between the HPS and the TLV sample filter.
interface tlv_sample_filter_if;
   logic [15:0] address;
   logic        read;
   logic [31:0] readdata;
   logic        write;
   logic [31:0] writedata;
   logic        waitrequest;

   modport master (
      output address, read, write, writedata,
      input  readdata, waitrequest
   );

   modport slave (
      input  address, read, write, writedata,
      output readdata, waitrequest
   );
endinterface

// File: rtl/tlv_moving_average.sv
// One channel of the moving-average filter: circular buffer of the last
// 2^LOG2_DEPTH samples, running sum and fill count. avg_next is the window
// average including the sample currently presented on din.
module tlv_moving_average #(
   parameter int WIDTH      = 13,
   parameter int LOG2_DEPTH = 2,
   parameter bit SIGNED_EN  = 1'b1
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] avg_next,
   output logic             primed,
   output logic             primed_next
);

   localparam int DEPTH = 1 << LOG2_DEPTH;
   localparam int SUM_W = WIDTH + LOG2_DEPTH;
   localparam int FILL_W = LOG2_DEPTH + 1;

   logic [WIDTH-1:0]      buf_mem [DEPTH];
   logic [LOG2_DEPTH-1:0] wr_ptr;
   logic [FILL_W-1:0]     fill_count;
   logic [SUM_W-1:0]      sum;
   logic [SUM_W-1:0]      sum_next;
   logic [SUM_W-1:0]      new_ext;
   logic [SUM_W-1:0]      old_ext;
   logic [WIDTH-1:0]      oldest;

   assign oldest  = buf_mem[wr_ptr];
   assign new_ext = SIGNED_EN ? {{LOG2_DEPTH{din[WIDTH-1]}}, din}
                              : {{LOG2_DEPTH{1'b0}}, din};
   assign old_ext = SIGNED_EN ? {{LOG2_DEPTH{oldest[WIDTH-1]}}, oldest}
                              : {{LOG2_DEPTH{1'b0}}, oldest};

   // The oldest entry drops out of the sum as the new one enters; empty slots hold 0
   assign sum_next    = sum + new_ext - old_ext;
   assign avg_next    = sum_next[SUM_W-1:LOG2_DEPTH];
   assign primed      = (fill_count == FILL_W'(DEPTH));
   assign primed_next = (fill_count >= FILL_W'(DEPTH - 1));

   // Buffer, pointer, sum and fill count; flush empties the window
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) buf_mem[i] <= '0;
         wr_ptr     <= '0;
         fill_count <= '0;
         sum        <= '0;
      end else if (flush) begin
         for (int i = 0; i < DEPTH; i++) buf_mem[i] <= '0;
         wr_ptr     <= '0;
         fill_count <= '0;
         sum        <= '0;
      end else if (push) begin
         buf_mem[wr_ptr] <= din;
         wr_ptr          <= wr_ptr + 1'b1;
         sum             <= sum_next;
         if (!primed) fill_count <= fill_count + 1'b1;
      end
   end

endmodule

// File: rtl/tlv_sample_filter.sv
// TLV493 sample filter: frame-continuity check, per-axis offset correction and
// a 2^LOG2_DEPTH moving average, with results and error counters on Avalon-MM.
// Optional feature macro: TLV_FILTER_SATURATE_EN (clip corrected axes to 12 bits).
module tlv_sample_filter
   import tlv_filter_pkg::*;
#(
   parameter int LOG2_DEPTH = 2,
   parameter int OUT_WIDTH  = 16
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 sample_valid,
   input  logic [11:0]          mag_x,
   input  logic [11:0]          mag_y,
   input  logic [11:0]          mag_z,
   input  logic [11:0]          temp,
   input  logic [1:0]           frm,
   tlv_sample_filter_if.slave   avs,
   output logic                 out_valid,
   output logic [OUT_WIDTH-1:0] x_filt,
   output logic [OUT_WIDTH-1:0] y_filt,
   output logic [OUT_WIDTH-1:0] z_filt,
   output logic [OUT_WIDTH-1:0] temp_filt
);

   state_t              state;
   logic [11:0]         lat_x, lat_y, lat_z, lat_temp;
   logic [1:0]          lat_frm, prev_frm;
   logic                prev_frm_valid, flush_pending, out_valid_q;
   logic [ENTRY_W-1:0]  corr_x, corr_y, corr_z;
   logic [11:0]         offset_x, offset_y, offset_z;
   logic [15:0]         overrun_count, frame_error_count;
   logic [7:0]          reg_sel;
   logic                flush_wr, clear_wr, frame_err, flush_now, primed, primed_next;
   logic [ENTRY_W-1:0]  ch_din [NUM_CHANNELS];
   logic [ENTRY_W-1:0]  ch_avg [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0] ch_primed, ch_primed_next;
   logic                unused_bits;

   // Offset correction in 13 bits, optionally clipped back to the raw 12-bit range
   function automatic logic [ENTRY_W-1:0] correct_axis(input logic [11:0] raw,
                                                       input logic [11:0] off);
      logic signed [12:0] diff;
      diff = $signed({raw[11], raw}) - $signed({off[11], off});
`ifdef TLV_FILTER_SATURATE_EN
      if (diff > 13'sd2047)       return 12'h7FF;
      else if (diff < -13'sd2048) return 12'h800;
      else                        return diff[11:0];
`else
      return diff;
`endif
   endfunction

   assign reg_sel     = avs.address[15:8];
   assign flush_wr    = avs.write && (reg_sel == WREG_FLUSH) && (avs.writedata[7:0] != 8'd0);
   assign clear_wr    = avs.write && (reg_sel == WREG_CLEAR) && (avs.writedata[7:0] != 8'd0);
   assign frame_err   = prev_frm_valid && (lat_frm != prev_frm + 2'd1);
   assign unused_bits = ^{avs.address[7:0], avs.writedata[31:12]};
   assign avs.waitrequest = 1'b0;

   // A flush in IDLE applies at once; one raised mid-sample waits for DONE exit
   assign flush_now = ((state == IDLE) && flush_wr)
                   || ((state == DONE) && (flush_pending || flush_wr))
                   || ((state == CHECK) && frame_err);

   // A flush arriving in the DONE cycle itself still withdraws that strobe
   assign out_valid = out_valid_q && !flush_wr;

   assign ch_din[0] = corr_x;
   assign ch_din[1] = corr_y;
   assign ch_din[2] = corr_z;
   assign ch_din[3] = ENTRY_W'(lat_temp);
   assign primed      = &ch_primed;
   assign primed_next = &ch_primed_next;

   for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_chan
      tlv_moving_average #(
         .WIDTH      (ENTRY_W),
         .LOG2_DEPTH (LOG2_DEPTH),
         .SIGNED_EN  (i != NUM_CHANNELS - 1)
      ) u_avg (
         .clock       (clock),
         .reset_n     (reset_n),
         .flush       (flush_now),
         .push        (state == UPDATE),
         .din         (ch_din[i]),
         .avg_next    (ch_avg[i]),
         .primed      (ch_primed[i]),
         .primed_next (ch_primed_next[i])
      );
   end

   // Sample-processing FSM with registered filtered outputs
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         lat_x          <= '0;
         lat_y          <= '0;
         lat_z          <= '0;
         lat_temp       <= '0;
         lat_frm        <= '0;
         prev_frm       <= '0;
         prev_frm_valid <= 1'b0;
         flush_pending  <= 1'b0;
         corr_x         <= '0;
         corr_y         <= '0;
         corr_z         <= '0;
         out_valid_q    <= 1'b0;
         x_filt         <= '0;
         y_filt         <= '0;
         z_filt         <= '0;
         temp_filt      <= '0;
      end else begin
         out_valid_q <= 1'b0;
         case (state)
            IDLE: begin
               if (sample_valid) begin
                  lat_x    <= mag_x;
                  lat_y    <= mag_y;
                  lat_z    <= mag_z;
                  lat_temp <= temp;
                  lat_frm  <= frm;
                  state    <= CHECK;
               end
            end
            CHECK: begin
               if (frame_err) begin
                  prev_frm       <= lat_frm;
                  prev_frm_valid <= 1'b1;
                  flush_pending  <= 1'b0;
                  state          <= IDLE;
               end else begin
                  corr_x <= correct_axis(lat_x, offset_x);
                  corr_y <= correct_axis(lat_y, offset_y);
                  corr_z <= correct_axis(lat_z, offset_z);
                  if (flush_wr) flush_pending <= 1'b1;
                  state <= UPDATE;
               end
            end
            UPDATE: begin
               x_filt      <= OUT_WIDTH'($signed(ch_avg[0]));
               y_filt      <= OUT_WIDTH'($signed(ch_avg[1]));
               z_filt      <= OUT_WIDTH'($signed(ch_avg[2]));
               temp_filt   <= OUT_WIDTH'(ch_avg[3]);
               out_valid_q <= primed_next && !flush_pending && !flush_wr;
               if (flush_wr) flush_pending <= 1'b1;
               state <= DONE;
            end
            DONE: begin
               prev_frm       <= lat_frm;
               prev_frm_valid <= 1'b1;
               flush_pending  <= 1'b0;
               state          <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Saturating error counters; a clear write beats a same-cycle increment
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         overrun_count     <= '0;
         frame_error_count <= '0;
      end else if (clear_wr) begin
         overrun_count     <= '0;
         frame_error_count <= '0;
      end else begin
         if (sample_valid && (state != IDLE) && (overrun_count != 16'hFFFF))
            overrun_count <= overrun_count + 16'd1;
         if ((state == CHECK) && frame_err && (frame_error_count != 16'hFFFF))
            frame_error_count <= frame_error_count + 16'd1;
      end
   end

   // Per-axis offset registers written by the HPS
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         offset_x <= '0;
         offset_y <= '0;
         offset_z <= '0;
      end else if (avs.write) begin
         if (reg_sel == WREG_OFFSET_X) offset_x <= avs.writedata[11:0];
         if (reg_sel == WREG_OFFSET_Y) offset_y <= avs.writedata[11:0];
         if (reg_sel == WREG_OFFSET_Z) offset_z <= avs.writedata[11:0];
      end
   end

   // Registered read mux; offsets read back as their raw 12-bit field
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         avs.readdata <= '0;
      end else if (avs.read) begin
         case (reg_sel)
            REG_X:         avs.readdata <= 32'($signed(x_filt));
            REG_Y:         avs.readdata <= 32'($signed(y_filt));
            REG_Z:         avs.readdata <= 32'($signed(z_filt));
            REG_TEMP:      avs.readdata <= 32'(temp_filt);
            REG_OVERRUN:   avs.readdata <= {16'd0, overrun_count};
            REG_FRAME_ERR: avs.readdata <= {16'd0, frame_error_count};
            REG_STATUS:    avs.readdata <= {29'd0, primed, state};
            REG_OFFSET_X:  avs.readdata <= {20'd0, offset_x};
            REG_OFFSET_Y:  avs.readdata <= {20'd0, offset_y};
            REG_OFFSET_Z:  avs.readdata <= {20'd0, offset_z};
            default:       avs.readdata <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_tlv_sample_filter.sv
// Self-checking bench for tlv_sample_filter (LOG2_DEPTH=2, OUT_WIDTH=16).
// Honours TLV_FILTER_SATURATE_EN in its reference model.
module tb_tlv_sample_filter;
   import tlv_filter_pkg::*;

   localparam int LOG2_DEPTH = 2;
   localparam int DEPTH      = 1 << LOG2_DEPTH;
   localparam int OUT_WIDTH  = 16;

   logic clock = 1'b0;
   logic reset_n;
   logic sample_valid;
   logic [11:0] mag_x, mag_y, mag_z, temp;
   logic [1:0]  frm;
   logic out_valid;
   logic [OUT_WIDTH-1:0] x_filt, y_filt, z_filt, temp_filt;

   tlv_sample_filter_if avs_bus ();

   tlv_sample_filter #(.LOG2_DEPTH(LOG2_DEPTH), .OUT_WIDTH(OUT_WIDTH)) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .sample_valid (sample_valid),
      .mag_x        (mag_x),
      .mag_y        (mag_y),
      .mag_z        (mag_z),
      .temp         (temp),
      .frm          (frm),
      .avs          (avs_bus.slave),
      .out_valid    (out_valid),
      .x_filt       (x_filt),
      .y_filt       (y_filt),
      .z_filt       (z_filt),
      .temp_filt    (temp_filt)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // Reference model: window contents as plain queues of corrected values
   int q_x[$], q_y[$], q_z[$], q_t[$];
   int m_prev_frm;
   bit m_prev_valid;
   int m_off_x, m_off_y, m_off_z;
   int m_overrun, m_frame_err;

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic check16(input string tag, input logic [15:0] observed, input int expected);
      logic [15:0] e16;
      e16 = 16'(expected);
      check_output(tag, {16'h0, observed}, {16'h0, e16});
   endtask

   function automatic int sext12(input int v);
      return (v >= 2048) ? v - 4096 : v;
   endfunction

   function automatic int model_corr(input int raw, input int off);
      int d;
      d = sext12(raw) - sext12(off);
`ifdef TLV_FILTER_SATURATE_EN
      if (d > 2047) d = 2047;
      if (d < -2048) d = -2048;
`endif
      return d;
   endfunction

   function automatic int q_avg(input int q[$]);
      int s;
      s = 0;
      foreach (q[i]) s += q[i];
      return s >>> LOG2_DEPTH;
   endfunction

   task automatic model_flush();
      q_x.delete(); q_y.delete(); q_z.delete(); q_t.delete();
   endtask

   task automatic model_reset();
      model_flush();
      m_prev_valid = 1'b0;
      m_prev_frm = 0;
      m_off_x = 0; m_off_y = 0; m_off_z = 0;
      m_overrun = 0; m_frame_err = 0;
   endtask

   task automatic model_step(input int x, input int y, input int z, input int t, input int f,
                             output bit ev, output int ex, output int ey, output int ez, output int et);
      ev = 1'b0; ex = 0; ey = 0; ez = 0; et = 0;
      if (m_prev_valid && (f != (m_prev_frm + 1) % 4)) begin
         if (m_frame_err < 65535) m_frame_err++;
         model_flush();
      end else begin
         q_x.push_back(model_corr(x, m_off_x));
         q_y.push_back(model_corr(y, m_off_y));
         q_z.push_back(model_corr(z, m_off_z));
         q_t.push_back(t);
         if (q_x.size() > DEPTH) begin
            void'(q_x.pop_front()); void'(q_y.pop_front());
            void'(q_z.pop_front()); void'(q_t.pop_front());
         end
         ev = (q_x.size() == DEPTH);
         ex = q_avg(q_x); ey = q_avg(q_y); ez = q_avg(q_z); et = q_avg(q_t);
      end
      m_prev_frm = f;
      m_prev_valid = 1'b1;
   endtask

   task automatic drive_sample(input logic [11:0] x, input logic [11:0] y, input logic [11:0] z,
                               input logic [11:0] t, input logic [1:0] f);
      sample_valid = 1'b1;
      mag_x = x; mag_y = y; mag_z = z; temp = t; frm = f;
   endtask

   // One complete sample: drive, then check the strobe in CHECK, UPDATE and DONE cycles
   task automatic apply_stimulus(input logic [11:0] x, input logic [11:0] y, input logic [11:0] z,
                                 input logic [11:0] t, input logic [1:0] f);
      bit ev;
      int ex, ey, ez, et;
      model_step(int'(x), int'(y), int'(z), int'(t), int'(f), ev, ex, ey, ez, et);
      @(negedge clock); drive_sample(x, y, z, t, f);
      @(negedge clock); sample_valid = 1'b0;
      check_output("valid_check_cycle", {31'd0, out_valid}, 32'd0);
      @(negedge clock);
      check_output("valid_update_cycle", {31'd0, out_valid}, 32'd0);
      @(negedge clock);
      check_output("valid_done_cycle", {31'd0, out_valid}, {31'd0, ev});
      if (ev) begin
         check16("x_filt", x_filt, ex);
         check16("y_filt", y_filt, ey);
         check16("z_filt", z_filt, ez);
         check16("temp_filt", temp_filt, et);
      end
   endtask

   task automatic av_write(input logic [7:0] sel, input logic [31:0] data);
      @(negedge clock);
      avs_bus.address = {sel, 8'h00};
      avs_bus.writedata = data;
      avs_bus.write = 1'b1;
      @(negedge clock);
      avs_bus.write = 1'b0;
      case (sel)
         8'd0: m_off_x = int'(data[11:0]);
         8'd1: m_off_y = int'(data[11:0]);
         8'd2: m_off_z = int'(data[11:0]);
         8'd3: if (data[7:0] != 8'd0) model_flush();
         8'd4: if (data[7:0] != 8'd0) begin m_overrun = 0; m_frame_err = 0; end
         default: ;
      endcase
   endtask

   task automatic av_read(input logic [7:0] sel, output logic [31:0] data);
      @(negedge clock);
      avs_bus.address = {sel, 8'h00};
      avs_bus.read = 1'b1;
      @(negedge clock);
      avs_bus.read = 1'b0;
      data = avs_bus.readdata;
   endtask

   // Guard against a stuck simulation
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] rd;
      bit ev;
      int ex, ey, ez, et;
      int valid_count;
      int sat_exp;
      logic [11:0] rx, ry, rz, rt;
      logic [1:0] rf;

      reset_n = 1'b0;
      sample_valid = 1'b0;
      mag_x = '0; mag_y = '0; mag_z = '0; temp = '0; frm = '0;
      avs_bus.address = '0; avs_bus.read = 1'b0; avs_bus.write = 1'b0; avs_bus.writedata = '0;
      model_reset();

      #12;
      $display("[TB] reset state");
      check_output("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check16("rst_x_filt", x_filt, 0);
      check16("rst_temp_filt", temp_filt, 0);
      check_output("rst_readdata", avs_bus.readdata, 32'd0);
      check_output("rst_waitrequest", {31'd0, avs_bus.waitrequest}, 32'd0);
      @(negedge clock); reset_n = 1'b1;
      av_read(REG_STATUS, rd);
      check_output("rst_status", rd, 32'd0);

      $display("[TB] priming with constant x=100");
      for (int i = 0; i < 4; i++) apply_stimulus(12'd100, 12'hFFB, 12'd7, 12'd300, 2'(i));
      check16("x_prime_100", x_filt, 100);
      av_read(REG_STATUS, rd);
      check_output("status_primed", rd, 32'd4);

      $display("[TB] window wrap");
      for (int i = 0; i < 4; i++) apply_stimulus(12'd0, 12'd0, 12'd0, 12'd0, 2'(i));
      apply_stimulus(12'd40, 12'd0, 12'd0, 12'd0, 2'd0);
      check16("x_wrap_10", x_filt, 10);

      $display("[TB] offset correction at negative full scale");
      av_write(WREG_OFFSET_X, 32'd10);
      for (int i = 1; i <= 4; i++) apply_stimulus(12'h800, 12'd0, 12'd0, 12'd0, 2'(i % 4));
`ifdef TLV_FILTER_SATURATE_EN
      sat_exp = -2048;
`else
      sat_exp = -2058;
`endif
      check16("x_offset_edge", x_filt, sat_exp);
      av_read(REG_X, rd);
      check_output("rd_x_sext", rd, 32'(sat_exp));
      av_read(REG_OFFSET_X, rd);
      check_output("rd_offset_x", rd, 32'd10);
      av_write(WREG_OFFSET_X, 32'd0);

      $display("[TB] frame discontinuity");
      av_write(WREG_CLEAR, 32'd1);
      apply_stimulus(12'd50, 12'd1, 12'd2, 12'd3, 2'd1);
      apply_stimulus(12'd50, 12'd1, 12'd2, 12'd3, 2'd2);
      apply_stimulus(12'd50, 12'd1, 12'd2, 12'd3, 2'd0);
      av_read(REG_FRAME_ERR, rd);
      check_output("frame_err_count", rd, 32'd1);
      for (int i = 1; i <= 4; i++) apply_stimulus(12'd60, 12'd5, 12'd6, 12'd9, 2'(i % 4));
      check16("x_reprimed", x_filt, 60);

      $display("[TB] flush raised during CHECK");
      model_step(20, 0, 0, 0, 1, ev, ex, ey, ez, et);
      model_flush();
      @(negedge clock); drive_sample(12'd20, 12'd0, 12'd0, 12'd0, 2'd1);
      @(negedge clock); sample_valid = 1'b0;
      avs_bus.address = {WREG_FLUSH, 8'h00}; avs_bus.writedata = 32'd1; avs_bus.write = 1'b1;
      @(negedge clock); avs_bus.write = 1'b0;
      check_output("flush_valid_update", {31'd0, out_valid}, 32'd0);
      @(negedge clock);
      check_output("flush_valid_done", {31'd0, out_valid}, 32'd0);
      av_read(REG_STATUS, rd);
      check_output("flush_status", rd, 32'd0);
      for (int i = 2; i <= 5; i++) apply_stimulus(12'd8, 12'd8, 12'd8, 12'd8, 2'(i % 4));

      $display("[TB] back-to-back samples");
      av_write(WREG_CLEAR, 32'd1);
      model_step(200, 0, 0, 0, 2, ev, ex, ey, ez, et);
      m_overrun++;
      @(negedge clock); drive_sample(12'd200, 12'd0, 12'd0, 12'd0, 2'd2);
      @(negedge clock); drive_sample(12'd999, 12'd0, 12'd0, 12'd0, 2'd3);
      @(negedge clock); sample_valid = 1'b0;
      valid_count = 0;
      for (int i = 0; i < 6; i++) begin
         if (out_valid) begin
            valid_count++;
            check16("overrun_x", x_filt, ex);
         end
         @(negedge clock);
      end
      check_output("overrun_valid_count", 32'(valid_count), 32'(ev ? 1 : 0));
      av_read(REG_OVERRUN, rd);
      check_output("overrun_count", rd, 32'd1);

      $display("[TB] randomized samples");
      for (int n = 0; n < 40; n++) begin
         if (n % 10 == 0) begin
            av_write(WREG_OFFSET_X, 32'($urandom_range(0, 4095)));
            av_write(WREG_OFFSET_Y, 32'($urandom_range(0, 4095)));
            av_write(WREG_OFFSET_Z, 32'($urandom_range(0, 4095)));
         end
         if (n % 13 == 7) av_write(WREG_FLUSH, 32'h80);
         rx = 12'($urandom_range(0, 4095));
         ry = 12'($urandom_range(0, 4095));
         rz = 12'($urandom_range(0, 4095));
         rt = 12'($urandom_range(0, 4095));
         rf = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'((m_prev_frm + 1) % 4);
         apply_stimulus(rx, ry, rz, rt, rf);
      end
      av_read(REG_FRAME_ERR, rd);
      check_output("rand_frame_err", rd, 32'(m_frame_err));
      av_read(REG_OVERRUN, rd);
      check_output("rand_overrun", rd, 32'(m_overrun));
      av_read(REG_STATUS, rd);
      check_output("rand_status", rd, (q_x.size() == DEPTH) ? 32'd4 : 32'd0);
      av_read(REG_OFFSET_Z, rd);
      check_output("rand_offset_z", rd, 32'(m_off_z));

      $display("[TB] reset during UPDATE");
      @(negedge clock); drive_sample(12'd33, 12'd33, 12'd33, 12'd33, 2'((m_prev_frm + 1) % 4));
      @(negedge clock); sample_valid = 1'b0;
      @(negedge clock); reset_n = 1'b0;
      #1;
      check_output("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      check16("mid_rst_x", x_filt, 0);
      check16("mid_rst_temp", temp_filt, 0);
      check_output("mid_rst_readdata", avs_bus.readdata, 32'd0);
      @(negedge clock); reset_n = 1'b1;
      model_reset();
      av_read(REG_OFFSET_X, rd);
      check_output("post_rst_offset_x", rd, 32'd0);
      av_read(REG_OVERRUN, rd);
      check_output("post_rst_overrun", rd, 32'd0);
      apply_stimulus(12'd77, 12'd0, 12'd0, 12'd0, 2'd3);
      apply_stimulus(12'd77, 12'd0, 12'd0, 12'd0, 2'd0);
      av_read(REG_FRAME_ERR, rd);
      check_output("post_rst_frame_err", rd, 32'd0);
      av_read(REG_STATUS, rd);
      check_output("post_rst_status", rd, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
